mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit_pkg.sv | 28 ++
 rtl/mc_wait_timer.sv | 51 +++++
 rtl/mc_control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// mc_control_unit_pkg
// Shared definitions for the multi-cycle control unit:
//   - state_e   : FSM state encoding (FETCH..WB, codes 0..4)
//   - OP_*      : supported opcode values (6-bit, zero-extended by users)
//   - ALU_*     : ALU operation class codes (2-bit, width-cast by users)
// ---------------------------------------------------------------------------
package mc_control_unit_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_RTYPE  = 2'b00;  // function field selects the op
  localparam logic [1:0] ALU_BRANCH = 2'b01;  // compare for beq
  localparam logic [1:0] ALU_MEM    = 2'b11;  // address generation

endpackage

// File: rtl/mc_wait_timer.sv
// ---------------------------------------------------------------------------
// mc_wait_timer
// Counts consecutive wait cycles while the FSM sits in a memory-access state
// (FETCH or MEM) and the memory has not answered. The count is held at zero
// outside those states, so it is always zero on entry to either of them.
// When a further wait cycle would push the count past WAIT_MAX, expire_o
// pulses for that cycle and the count restarts from zero.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   active_i    in   FSM is in FETCH or MEM
//   mem_ready_i in   memory completes the access this cycle
//   expire_o    out  wait overrun this cycle (combinational)
// ---------------------------------------------------------------------------
module mc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic mem_ready_i,
  output logic expire_o
);

  localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             waiting;

  assign waiting  = active_i && !mem_ready_i;
  // Count already at the limit and another wait cycle arrives: overrun.
  assign expire_o = waiting && (cnt_q == CNT_W'(WAIT_MAX));

  always_comb begin
    cnt_d = '0;
    if (waiting && !expire_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
// Moore-style multi-cycle control FSM (FETCH, DECODE, EXEC, MEM, WB) for a
// small MIPS-like datapath. Supports R-type, lw, sw, beq; with the build
// macro MC_JUMP_EN defined, opcode 000010 (j) is also legal and completes in
// EXEC. Without MC_JUMP_EN the jump output is constant 0 and 000010 is
// reported as illegal.
//
// Datapath controls decode from the current state and the captured opcode
// register. The only same-cycle input dependencies are the memory handshake
// (ir_write/pc_write on FETCH completion) and the wait-overrun handling,
// which drops mem_read/mem_write in the overrun cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode            instruction opcode, sampled in DECODE
//   mem_ready         memory completes the current access (FETCH/MEM only)
//   pc_write,ir_write PC update / instruction-register load
//   reg_dst, memto_reg, alu_src, branch, jump,
//   mem_read, mem_write, reg_write   datapath controls
//   alu_op            ALU operation class
//   state             current FSM state code
//   illegal_op        one-cycle pulse on an unsupported opcode (DECODE)
//   timeout           one-cycle pulse on a memory wait overrun
//   retired           completed-instruction count, wraps
// ---------------------------------------------------------------------------
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int WAIT_MAX = 15,
  parameter int RET_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                memto_reg,
  output logic                alu_src,
  output logic                branch,
  output logic                jump,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [2:0]          state,
  output logic                illegal_op,
  output logic                timeout,
  output logic [RET_W-1:0]    retired
);

  localparam logic [OPCODE_W-1:0] OPC_R   = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] OPC_LW  = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] OPC_SW  = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] OPC_BEQ = OPCODE_W'(OP_BEQ);
`ifdef MC_JUMP_EN
  localparam logic [OPCODE_W-1:0] OPC_J   = OPCODE_W'(OP_J);
`endif

  localparam logic [ALUOP_W-1:0] AOP_R   = ALUOP_W'(ALU_RTYPE);
  localparam logic [ALUOP_W-1:0] AOP_BR  = ALUOP_W'(ALU_BRANCH);
  localparam logic [ALUOP_W-1:0] AOP_MEM = ALUOP_W'(ALU_MEM);

  state_e              state_q;
  state_e              state_d;
  logic [OPCODE_W-1:0] opcode_q;
  logic [RET_W-1:0]    retired_q;
  logic                retire;
  logic                tmo;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    logic ok;
    ok = (op == OPC_R) || (op == OPC_LW) || (op == OPC_SW) || (op == OPC_BEQ);
`ifdef MC_JUMP_EN
    ok = ok || (op == OPC_J);
`endif
    return ok;
  endfunction

  mc_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .active_i    ((state_q == S_FETCH) || (state_q == S_MEM)),
    .mem_ready_i (mem_ready),
    .expire_o    (tmo)
  );

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    memto_reg  = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_op     = '0;
    illegal_op = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read = !tmo;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
        // An overrun simply restarts FETCH; the timer clears itself.
      end

      S_DECODE: begin
        if (is_legal(opcode)) begin
          state_d = S_EXEC;
        end else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        if (opcode_q == OPC_R) begin
          reg_dst = 1'b1;
          alu_op  = AOP_R;
          state_d = S_WB;
        end else if ((opcode_q == OPC_LW) || (opcode_q == OPC_SW)) begin
          alu_op  = AOP_MEM;
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (opcode_q == OPC_BEQ) begin
          alu_op = AOP_BR;
          branch = 1'b1;
          retire = 1'b1;
        end
`ifdef MC_JUMP_EN
        else if (opcode_q == OPC_J) begin
          jump     = 1'b1;
          pc_write = 1'b1;
          retire   = 1'b1;
        end
`endif
      end

      S_MEM: begin
        // Address stays selected for the whole access, including waits.
        alu_src   = 1'b1;
        mem_read  = (opcode_q == OPC_LW) && !tmo;
        mem_write = (opcode_q == OPC_SW) && !tmo;
        if (mem_ready) begin
          if (opcode_q == OPC_LW) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (tmo) begin
          state_d = S_FETCH;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        memto_reg = (opcode_q == OPC_LW);
        reg_dst   = (opcode_q == OPC_R);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        opcode_q <= opcode;
      end
      if (retire) begin
        retired_q <= retired_q + RET_W'(1);
      end
    end
  end

  assign state   = state_q;
  assign timeout = tmo;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_control_unit
// Directed per-cycle vectors. Each stimulus step pushes the hand-computed
// expected outputs for that cycle into a queue; a monitor on the falling
// edge pops and compares. Control vector bit order:
//   pc_write ir_write reg_dst memto_reg alu_src branch jump
//   mem_read mem_write reg_write illegal_op timeout
// ---------------------------------------------------------------------------
module tb_mc_control_unit;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, ir_write, reg_dst, memto_reg, alu_src, branch, jump;
  logic        mem_read, mem_write, reg_write, illegal_op, timeout;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] retired;

  mc_control_unit #(
    .OPCODE_W (6),
    .ALUOP_W  (2),
    .WAIT_MAX (15),
    .RET_W    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .memto_reg  (memto_reg),
    .alu_src    (alu_src),
    .branch     (branch),
    .jump       (jump),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .state      (state),
    .illegal_op (illegal_op),
    .timeout    (timeout),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [11:0] ctl;
    logic [1:0]  aop;
    logic [15:0] ret;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  localparam logic [11:0] C_0   = 12'b000000000000;
  localparam logic [11:0] C_MR  = 12'b000000010000;
  localparam logic [11:0] C_FOK = 12'b110000010000;
  localparam logic [11:0] C_RX  = 12'b001000000000;
  localparam logic [11:0] C_RWB = 12'b001000000100;
  localparam logic [11:0] C_AS  = 12'b000010000000;
  localparam logic [11:0] C_LWM = 12'b000010010000;
  localparam logic [11:0] C_SWM = 12'b000010001000;
  localparam logic [11:0] C_LWB = 12'b000100000100;
  localparam logic [11:0] C_BR  = 12'b000001000000;
  localparam logic [11:0] C_ILL = 12'b000000000010;
  localparam logic [11:0] C_TO  = 12'b000000000001;
  localparam logic [11:0] C_MTO = 12'b000010000001;
`ifdef MC_JUMP_EN
  localparam logic [11:0] C_J   = 12'b100000100000;
  localparam logic [15:0] RJ    = 16'd1;
`else
  localparam logic [15:0] RJ    = 16'd0;
`endif

  // Monitor / scoreboard.
  exp_t        m_e;
  string       m_t;
  logic [11:0] m_ctl;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_t   = tag_q.pop_front();
      m_ctl = {pc_write, ir_write, reg_dst, memto_reg, alu_src, branch, jump,
               mem_read, mem_write, reg_write, illegal_op, timeout};
      n_tests++;
      if (state !== m_e.st || m_ctl !== m_e.ctl || alu_op !== m_e.aop ||
          retired !== m_e.ret) begin
        n_fail++;
        $display("FAIL %s: got state=%0d ctl=%b alu_op=%b retired=%0d, expected state=%0d ctl=%b alu_op=%b retired=%0d",
                 m_t, state, m_ctl, alu_op, retired, m_e.st, m_e.ctl, m_e.aop, m_e.ret);
      end
    end
  end

  task automatic step(input string tag, input logic rst, input logic mr,
                      input logic [2:0] st, input logic [11:0] ctl,
                      input logic [1:0] aop, input logic [15:0] ret);
    exp_t e;
    rst_n     = rst;
    mem_ready = mr;
    e.st  = st;
    e.ctl = ctl;
    e.aop = aop;
    e.ret = ret;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input string name, input int cycles);
    $display("[TB] txn %s: %0d cycles checked", name, cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'b000000;
    @(posedge clk);
    #1;
    step("reset", 0, 0, 3'd0, C_MR, 2'b00, 16'd0);
    txn("reset", 1);

    // R-type, mem_ready always high (ignored outside FETCH/MEM).
    opcode = 6'b000000;
    step("r_fetch",  1, 1, 3'd0, C_FOK, 2'b00, 16'd0);
    step("r_decode", 1, 1, 3'd1, C_0,   2'b00, 16'd0);
    step("r_exec",   1, 1, 3'd2, C_RX,  2'b00, 16'd0);
    step("r_wb",     1, 1, 3'd4, C_RWB, 2'b00, 16'd0);
    txn("rtype", 4);

    // lw with three wait cycles in MEM: 8 cycles total.
    opcode = 6'b100011;
    step("lw_fetch",  1, 1, 3'd0, C_FOK, 2'b00, 16'd1);
    step("lw_decode", 1, 0, 3'd1, C_0,   2'b00, 16'd1);
    step("lw_exec",   1, 0, 3'd2, C_AS,  2'b11, 16'd1);
    for (int i = 0; i < 3; i++) step("lw_mem_wait", 1, 0, 3'd3, C_LWM, 2'b00, 16'd1);
    step("lw_mem_done", 1, 1, 3'd3, C_LWM, 2'b00, 16'd1);
    step("lw_wb",       1, 0, 3'd4, C_LWB, 2'b00, 16'd1);
    txn("lw", 8);

    // sw zero wait.
    opcode = 6'b101011;
    step("sw_fetch",  1, 1, 3'd0, C_FOK, 2'b00, 16'd2);
    step("sw_decode", 1, 0, 3'd1, C_0,   2'b00, 16'd2);
    step("sw_exec",   1, 0, 3'd2, C_AS,  2'b11, 16'd2);
    step("sw_mem",    1, 1, 3'd3, C_SWM, 2'b00, 16'd2);
    txn("sw", 4);

    // beq.
    opcode = 6'b000100;
    step("beq_fetch",  1, 1, 3'd0, C_FOK, 2'b00, 16'd3);
    step("beq_decode", 1, 0, 3'd1, C_0,   2'b00, 16'd3);
    step("beq_exec",   1, 0, 3'd2, C_BR,  2'b01, 16'd3);
    txn("beq", 3);

    // Illegal opcode: no retire.
    opcode = 6'b111111;
    step("ill_fetch",  1, 1, 3'd0, C_FOK, 2'b00, 16'd4);
    step("ill_decode", 1, 0, 3'd1, C_ILL, 2'b00, 16'd4);
    txn("illegal", 2);

    // Jump: legal only with MC_JUMP_EN.
    opcode = 6'b000010;
    step("j_fetch", 1, 1, 3'd0, C_FOK, 2'b00, 16'd4);
`ifdef MC_JUMP_EN
    step("j_decode", 1, 0, 3'd1, C_0, 2'b00, 16'd4);
    step("j_exec",   1, 0, 3'd2, C_J, 2'b00, 16'd4);
    txn("jump", 3);
`else
    step("j_decode_illegal", 1, 0, 3'd1, C_ILL, 2'b00, 16'd4);
    txn("jump_disabled", 2);
`endif

    // FETCH timeout in the 16th wait cycle, then a full 15-cycle wait
    // without overrun proves the counter restarted from zero.
    opcode = 6'b101011;
    for (int i = 0; i < 15; i++) step("fetch_wait", 1, 0, 3'd0, C_MR, 2'b00, 16'd4 + RJ);
    step("fetch_timeout", 1, 0, 3'd0, C_TO, 2'b00, 16'd4 + RJ);
    for (int i = 0; i < 15; i++) step("fetch_rewait", 1, 0, 3'd0, C_MR, 2'b00, 16'd4 + RJ);
    txn("fetch_timeout", 31);

    // sw interrupted by reset in MEM.
    step("swr_fetch",  1, 1, 3'd0, C_FOK, 2'b00, 16'd4 + RJ);
    step("swr_decode", 1, 0, 3'd1, C_0,   2'b00, 16'd4 + RJ);
    step("swr_exec",   1, 0, 3'd2, C_AS,  2'b11, 16'd4 + RJ);
    step("swr_mem",    1, 0, 3'd3, C_SWM, 2'b00, 16'd4 + RJ);
    step("swr_reset",  0, 0, 3'd0, C_MR,  2'b00, 16'd0);
    txn("sw_reset", 5);

    // lw MEM overrun: mem_read drops in the 16th wait cycle, no retire.
    opcode = 6'b100011;
    step("lwt_fetch",  1, 1, 3'd0, C_FOK, 2'b00, 16'd0);
    step("lwt_decode", 1, 0, 3'd1, C_0,   2'b00, 16'd0);
    step("lwt_exec",   1, 0, 3'd2, C_AS,  2'b11, 16'd0);
    for (int i = 0; i < 15; i++) step("lwt_mem_wait", 1, 0, 3'd3, C_LWM, 2'b00, 16'd0);
    step("lwt_mem_timeout", 1, 0, 3'd3, C_MTO, 2'b00, 16'd0);
    step("lwt_back_fetch",  1, 0, 3'd0, C_MR,  2'b00, 16'd0);
    txn("lw_mem_timeout", 20);

    // Every pushed expectation must have been consumed by the monitor.
    repeat (4) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
